alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execution-side consumer of the 3-bit ALUControl code produced by the ALU decoder.
- Executes add/sub in one cycle and multiply/divide iteratively (shift-add, restoring division).
- Uses a start/busy/done handshake so the datapath/control FSM can stall during long operations.
- Sits between the register-file operand muxes (SrcA/SrcB) and the writeback result mux.

Parameters:
WIDTH, 32, operand and result width in bits (>=4).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
ALUControl  input  3  000 add, 001 sub, 010 mul, 011 div, others = add
SrcA  input  WIDTH  operand A (dividend for div)
SrcB  input  WIDTH  operand B (divisor for div)
ALUResult  output  WIDTH  registered result; held until next done
Flags  output  4  {N,Z,C,V}; registered with ALUResult
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse; ALUResult/Flags valid from this cycle
div_by_zero  output  1  registered with done; high only for div with SrcB==0

Behaviour:
- Reset (synchronous, active-high, dominates everything): state=IDLE, ALUResult=0, Flags=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts it with no done pulse.
- States: IDLE, MUL, DIV, FIN.
- IDLE + start:
  - Latch ALUControl, SrcA, SrcB.
  - add/sub/undefined code -> FIN.
  - mul -> MUL, count=0.
  - div with SrcB!=0 -> DIV, count=0.
  - div with SrcB==0 -> FIN with div_by_zero pending.
- start while busy or in FIN is ignored; operands are not re-latched.
- MUL: one multiplier bit per cycle, LSB first; accumulator of WIDTH bits, result = low WIDTH bits of unsigned product. After WIDTH iterations -> FIN.
- DIV: one restoring step per cycle, MSB first, unsigned; result = quotient, remainder discarded. After WIDTH iterations -> FIN.
- FIN: drive ALUResult and Flags, pulse done=1 for one cycle, then return to IDLE. A new start is accepted the cycle after FIN.
- busy=1 in MUL, DIV, FIN; done=1 only in FIN.
- Latency, start cycle to done cycle:
  - add/sub/undefined/div-by-zero: 1 cycle.
  - mul/div: WIDTH+1 cycles (33 at WIDTH=32).
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - C = carry-out for add; C = NOT borrow for sub (A>=B unsigned gives C=1).
  - V = two's-complement overflow for add/sub; C=V=0 for mul/div.
  - N = ALUResult[WIDTH-1]; Z = (ALUResult==0).
- Div by zero: ALUResult = all ones, Z=0, N=1, C=V=0, div_by_zero=1.
- div_by_zero is cleared at the next accepted start.

Optional Feature:
- Macro ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL moves to FIN as soon as all remaining unshifted multiplier bits are zero. Latency is (index of highest set bit of SrcB)+2 cycles; SrcB==0 gives 1 cycle (IDLE -> FIN directly). Results are identical to the non-early-exit case.
- Undefined: MUL always runs exactly WIDTH iterations.
- DIV latency is unaffected either way.

Test Plan:
- add: SrcA=0x7FFFFFFF, SrcB=1, code 000 -> done 1 cycle later, ALUResult=0x80000000, N=1 Z=0 C=0 V=1.
- sub: SrcA=5, SrcB=5, code 001 -> ALUResult=0, Z=1 C=1 V=0; then SrcA=3, SrcB=5 -> 0xFFFFFFFE, N=1 C=0.
- mul: SrcA=0x00010001, SrcB=0x00010001, code 010 -> done at cycle 33 (macro off), ALUResult=0x00020001, busy high cycles 1..33. With macro on and SrcB=0x10: done at cycle 6, ALUResult=0x00100010.
- div: SrcA=100, SrcB=7 -> ALUResult=14 at cycle 33. div: SrcA=9, SrcB=0 -> done cycle 1, ALUResult=0xFFFFFFFF, div_by_zero=1.
- Handshake/reset: start mul, pulse start with div at cycle 5 -> ignored, mul result returned. Assert reset at cycle 10 of a div -> all outputs 0 next cycle, no done pulse, fresh add accepted after reset deasserts.
- Undefined code 110 with SrcA=2, SrcB=3 -> ALUResult=5 after 1 cycle.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the control datapath and alu_multicycle.
// master drives the operation request; slave is the ALU itself.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       Flags;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  ALUResult, Flags, busy, done, div_by_zero
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output ALUResult, Flags, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub, iterative shift-add multiply and restoring divide.
// Define ALU_MUL_EARLY_EXIT_EN to end a multiply once the remaining multiplier bits are zero.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_multicycle_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] a_reg, a_next;       // multiplicand (mul) / dividend-quotient shifter (div)
  logic [WIDTH-1:0] b_reg, b_next;       // multiplier (mul) / divisor (div)
  logic [WIDTH-1:0] acc_reg, acc_next;   // product accumulator (mul) / partial remainder (div)
  logic [WIDTH-1:0] result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   add_sum, sub_diff, rem_sh;
  logic [WIDTH-1:0] mul_step, rem_diff, q_step;
  logic             fits, last_iter;

  function automatic logic [1:0] nz(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], r == '0};
  endfunction

  assign add_sum  = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
  assign sub_diff = {1'b0, bus.SrcA} - {1'b0, bus.SrcB};
  assign mul_step = acc_reg + (b_reg[0] ? a_reg : '0);
  assign rem_sh   = {acc_reg, a_reg[WIDTH-1]};
  assign fits     = rem_sh >= {1'b0, b_reg};
  // When the divisor fits, the difference is below the divisor, so WIDTH bits suffice.
  assign rem_diff = rem_sh[WIDTH-1:0] - b_reg;
  assign q_step   = {a_reg[WIDTH-2:0], fits};

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_iter = (count_reg == CW'(WIDTH - 1)) ||
                     (state_reg == MUL && b_reg[WIDTH-1:1] == '0);
`else
  assign last_iter = (count_reg == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    dbz_next    = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.SrcA;
          b_next     = bus.SrcB;
          count_next = '0;
          acc_next   = '0;
          dbz_next   = 1'b0;
          case (bus.ALUControl)
            3'b001: begin
              state_next  = FIN;
              result_next = sub_diff[WIDTH-1:0];
              flags_next  = {nz(sub_diff[WIDTH-1:0]), ~sub_diff[WIDTH],
                             (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) &&
                             (sub_diff[WIDTH-1] != bus.SrcA[WIDTH-1])};
            end
            3'b010: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
              if (bus.SrcB == '0) begin
                state_next  = FIN;
                result_next = '0;
                flags_next  = 4'b0100;
              end else begin
                state_next = MUL;
              end
`else
              state_next = MUL;
`endif
            end
            3'b011: begin
              if (bus.SrcB == '0) begin
                state_next  = FIN;
                result_next = '1;
                flags_next  = 4'b1000;
                dbz_next    = 1'b1;
              end else begin
                state_next = DIV;
              end
            end
            default: begin
              state_next  = FIN;
              result_next = add_sum[WIDTH-1:0];
              flags_next  = {nz(add_sum[WIDTH-1:0]), add_sum[WIDTH],
                             (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != bus.SrcA[WIDTH-1])};
            end
          endcase
        end
      end
      MUL: begin
        acc_next   = mul_step;
        a_next     = a_reg << 1;
        b_next     = b_reg >> 1;
        count_next = count_reg + CW'(1);
        if (last_iter) begin
          state_next  = FIN;
          result_next = mul_step;
          flags_next  = {nz(mul_step), 2'b00};
        end
      end
      DIV: begin
        acc_next   = fits ? rem_diff : rem_sh[WIDTH-1:0];
        a_next     = q_step;
        count_next = count_reg + CW'(1);
        if (last_iter) begin
          state_next  = FIN;
          result_next = q_step;
          flags_next  = {nz(q_step), 2'b00};
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      dbz_reg    <= dbz_next;
    end
  end

  assign bus.ALUResult   = result_reg;
  assign bus.Flags       = flags_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: latency, results, flags, handshake and reset abort.
// Expected multiply latencies follow ALU_MUL_EARLY_EXIT_EN when it is defined.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  alu_multicycle_if #(.WIDTH(32)) bus();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ALUControl = code;
    bus.SrcA       = a;
    bus.SrcB       = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Runs one operation; inj > 0 pulses a conflicting div start during that cycle.
  task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_dbz, input int inj);
    int lat;
    logic busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    launch(code, a, b);
    for (int k = 1; k <= 60; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == inj) begin
        bus.start = 1'b1;
        bus.ALUControl = 3'b011;
        bus.SrcA = 32'd100;
        bus.SrcB = 32'd7;
      end
      @(posedge clk);
      #1;
      if (k == inj) bus.start = 1'b0;
    end
    $display("op %s: code=%b A=%h B=%h lat=%0d result=%h flags=%b dbz=%b",
             tag, code, a, b, lat, bus.ALUResult, bus.Flags, bus.div_by_zero);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".result"}, bus.ALUResult, exp_res);
    check({tag, ".flags"}, bus.Flags, exp_flags);
    check({tag, ".dbz"}, bus.div_by_zero, exp_dbz);
    check({tag, ".busy"}, busy_ok, 1'b1);
    @(posedge clk);
    #1;
    check({tag, ".idle_after"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    logic no_done;
    int lat_mul_big, lat_mul_x10, lat_mul_ovf, lat_mul_inj;
`ifdef ALU_MUL_EARLY_EXIT_EN
    lat_mul_big = 18; lat_mul_x10 = 6; lat_mul_ovf = 3; lat_mul_inj = 10;
`else
    lat_mul_big = 33; lat_mul_x10 = 33; lat_mul_ovf = 33; lat_mul_inj = 33;
`endif
    bus.start = 1'b0;
    bus.ALUControl = 3'b000;
    bus.SrcA = '0;
    bus.SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", {bus.ALUResult, bus.Flags, bus.busy, bus.done, bus.div_by_zero}, '0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add_ovf",  3'b000, 32'h7FFFFFFF, 32'h1,        1,  32'h80000000, 4'b1001, 1'b0, 0);
    run_op("add_carry",3'b000, 32'hFFFFFFFF, 32'h1,        1,  32'h0,        4'b0110, 1'b0, 0);
    run_op("sub_eq",   3'b001, 32'd5,        32'd5,        1,  32'h0,        4'b0110, 1'b0, 0);
    run_op("sub_neg",  3'b001, 32'd3,        32'd5,        1,  32'hFFFFFFFE, 4'b1000, 1'b0, 0);
    run_op("mul_big",  3'b010, 32'h00010001, 32'h00010001, lat_mul_big, 32'h00020001, 4'b0000, 1'b0, 0);
    run_op("mul_x10",  3'b010, 32'h00010001, 32'h10,       lat_mul_x10, 32'h00100010, 4'b0000, 1'b0, 0);
    run_op("mul_ovf",  3'b010, 32'h80000000, 32'd3,        lat_mul_ovf, 32'h80000000, 4'b1000, 1'b0, 0);
    run_op("div",      3'b011, 32'd100,      32'd7,        33, 32'd14,       4'b0000, 1'b0, 0);
    run_op("div_zero", 3'b011, 32'd9,        32'd0,        1,  32'hFFFFFFFF, 4'b1000, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("div_zero.hold", {bus.ALUResult, bus.div_by_zero}, {32'hFFFFFFFF, 1'b1});

    run_op("undef",    3'b110, 32'd2,        32'd3,        1,  32'd5,        4'b0000, 1'b0, 0);
    run_op("mul_inj",  3'b010, 32'd6,        32'h107,      lat_mul_inj, 32'h62A, 4'b0000, 1'b0, 5);

    // Abort a divide partway through with reset.
    no_done = 1'b1;
    launch(3'b011, 32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) begin
      if (bus.done === 1'b1) no_done = 1'b0;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("reset mid-div: result=%h flags=%b busy=%b done=%b dbz=%b",
             bus.ALUResult, bus.Flags, bus.busy, bus.done, bus.div_by_zero);
    check("abort.outputs", {bus.ALUResult, bus.Flags, bus.busy, bus.done, bus.div_by_zero}, '0);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) no_done = 1'b0;
      @(posedge clk);
      #1;
    end
    check("abort.no_done", no_done, 1'b1);

    run_op("post_reset", 3'b000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
